// File: rtl/multi_gate_delay_gen.sv
// N-channel gate/delay generator: one synchronised external trigger starts a delayed,
// fixed-width gate on every enabled channel, with per-shot latched settings.
module multi_gate_delay_gen #(
    parameter int N_CH        = 4,
    parameter int CNT_W       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_trigger,
    input  logic [N_CH-1:0]       i_en,
    input  logic [N_CH*CNT_W-1:0] i_delay,
    input  logic [N_CH*CNT_W-1:0] i_width,
    output logic [N_CH-1:0]       o_pulse,
    output logic [N_CH-1:0]       o_busy,
    output logic [N_CH-1:0]       o_miss,
    output logic [CNT_W-1:0]      o_trig_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DELAY = 2'd1,
        GATE  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   evt_q;
    logic [CNT_W-1:0]       trig_cnt_q;

    // Synchroniser, edge detect and event counter; evt_q is the one-cycle trigger event.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync_q     <= '0;
            prev_q     <= 1'b0;
            evt_q      <= 1'b0;
            trig_cnt_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], i_trigger};
            prev_q <= sync_q[SYNC_STAGES-1];
            evt_q  <= sync_q[SYNC_STAGES-1] & ~prev_q;
            if (evt_q) begin
                trig_cnt_q <= trig_cnt_q + ONE;
            end
        end
    end

    assign o_trig_cnt = trig_cnt_q;

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        state_t           state_q, state_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic [CNT_W-1:0] width_q, width_d;
        logic             miss_d, miss_q;
        logic             pulse_q, busy_q;
        logic [CNT_W-1:0] dly, wid;

        assign dly = i_delay[k*CNT_W +: CNT_W];
        assign wid = i_width[k*CNT_W +: CNT_W];

        // cnt_q holds remaining cycles minus one of the current phase, so delay and
        // width are counted separately and the full CNT_W range never wraps.
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            width_d = width_q;
            miss_d  = 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (evt_q && i_en[k] && (wid != '0)) begin
                        width_d = wid;
                        if (dly != '0) begin
                            state_d = DELAY;
                            cnt_d   = dly - ONE;
                        end else begin
                            state_d = GATE;
                            cnt_d   = wid - ONE;
                        end
                    end
                end
                DELAY: begin
                    if (!i_en[k]) begin
                        state_d = IDLE;
                    end else begin
                        miss_d = evt_q;
                        if (cnt_q == '0) begin
                            state_d = GATE;
                            cnt_d   = width_q - ONE;
                        end else begin
                            cnt_d = cnt_q - ONE;
                        end
                    end
                end
                GATE: begin
                    if (!i_en[k]) begin
                        state_d = IDLE;
                    end else begin
                        miss_d = evt_q;
                        if (cnt_q == '0) begin
                            state_d = IDLE;
                        end else begin
                            cnt_d = cnt_q - ONE;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                state_q <= IDLE;
                cnt_q   <= '0;
                width_q <= '0;
                miss_q  <= 1'b0;
                pulse_q <= 1'b0;
                busy_q  <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                width_q <= width_d;
                miss_q  <= miss_d;
                pulse_q <= (state_d == GATE);
                busy_q  <= (state_d != IDLE);
            end
        end

        assign o_pulse[k] = pulse_q;
        assign o_busy[k]  = busy_q;
        assign o_miss[k]  = miss_q;
    end

endmodule

// File: tb/tb_multi_gate_delay_gen.sv
// Directed bench for multi_gate_delay_gen (4 channels, 8-bit counters, 2 sync stages).
module tb_multi_gate_delay_gen;
    localparam int N_CH        = 4;
    localparam int CNT_W       = 8;
    localparam int SYNC_STAGES = 2;

    logic                  i_clk = 1'b0;
    logic                  i_rst_n;
    logic                  i_trigger;
    logic [N_CH-1:0]       i_en;
    logic [N_CH*CNT_W-1:0] i_delay;
    logic [N_CH*CNT_W-1:0] i_width;
    logic [N_CH-1:0]       o_pulse;
    logic [N_CH-1:0]       o_busy;
    logic [N_CH-1:0]       o_miss;
    logic [CNT_W-1:0]      o_trig_cnt;

    int               checks   = 0;
    int               failures = 0;
    logic [CNT_W-1:0] exp_cnt;

    multi_gate_delay_gen #(
        .N_CH(N_CH),
        .CNT_W(CNT_W),
        .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .i_clk(i_clk),
        .i_rst_n(i_rst_n),
        .i_trigger(i_trigger),
        .i_en(i_en),
        .i_delay(i_delay),
        .i_width(i_width),
        .o_pulse(o_pulse),
        .o_busy(o_busy),
        .o_miss(o_miss),
        .o_trig_cnt(o_trig_cnt)
    );

    always #5 i_clk = ~i_clk;

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic set_ch(input int ch, input int d, input int w);
        i_delay[ch*CNT_W +: CNT_W] = CNT_W'(d);
        i_width[ch*CNT_W +: CNT_W] = CNT_W'(w);
    endtask

    // Trigger is raised at k=0 (1ns after an edge); the event cycle T is k=3, so m = k-3.
    task automatic test_reset();
        i_en = '1;
        set_ch(0, 1, 1); set_ch(1, 0, 2); set_ch(2, 3, 3); set_ch(3, 0, 1);
        for (int k = 0; k < 10; k++) begin
            i_trigger = k[1];
            step();
            checks++;
            if (o_pulse !== 4'b0) begin failures++; $display("FAIL rst_pulse k=%0d got=%b exp=0000", k, o_pulse); end
            checks++;
            if (o_busy !== 4'b0) begin failures++; $display("FAIL rst_busy k=%0d got=%b exp=0000", k, o_busy); end
            checks++;
            if (o_miss !== 4'b0) begin failures++; $display("FAIL rst_miss k=%0d got=%b exp=0000", k, o_miss); end
            checks++;
            if (o_trig_cnt !== 8'd0) begin failures++; $display("FAIL rst_cnt k=%0d got=%0d exp=0", k, o_trig_cnt); end
        end
        i_trigger = 1'b0;
        i_en = '0;
        step();
        i_rst_n = 1'b1;
        idle(3);
        exp_cnt = '0;
        checks++;
        if (o_trig_cnt !== 8'd0) begin failures++; $display("FAIL rst_release_cnt got=%0d exp=0", o_trig_cnt); end
        checks++;
        if (o_busy !== 4'b0) begin failures++; $display("FAIL rst_release_busy got=%b exp=0000", o_busy); end
    endtask

    task automatic test_basic();
        logic [N_CH-1:0] eb, ep;
        int m;
        i_en = 4'b0001;
        set_ch(0, 5, 3);
        idle(2);
        i_trigger = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            step();
            m  = k - 3;
            eb = {3'b000, (m >= 1 && m <= 8)};
            ep = {3'b000, (m >= 6 && m <= 8)};
            checks++;
            if (o_busy !== eb) begin failures++; $display("FAIL basic_busy m=%0d got=%b exp=%b", m, o_busy, eb); end
            checks++;
            if (o_pulse !== ep) begin failures++; $display("FAIL basic_pulse m=%0d got=%b exp=%b", m, o_pulse, ep); end
            checks++;
            if (o_miss !== 4'b0) begin failures++; $display("FAIL basic_miss m=%0d got=%b exp=0000", m, o_miss); end
            if (k == 4) i_trigger = 1'b0;
        end
        exp_cnt = exp_cnt + 8'd1;
        checks++;
        if (o_trig_cnt !== exp_cnt) begin failures++; $display("FAIL basic_cnt got=%0d exp=%0d", o_trig_cnt, exp_cnt); end
    endtask

    task automatic test_independent();
        logic [N_CH-1:0] eb, ep;
        int m;
        i_en = 4'b1111;
        set_ch(0, 0, 4); set_ch(1, 2, 1); set_ch(2, 10, 2); set_ch(3, 3, 0);
        idle(2);
        i_trigger = 1'b1;
        for (int k = 1; k <= 18; k++) begin
            step();
            m  = k - 3;
            eb = {1'b0, (m >= 1 && m <= 12), (m >= 1 && m <= 3), (m >= 1 && m <= 4)};
            ep = {1'b0, (m >= 11 && m <= 12), (m == 3), (m >= 1 && m <= 4)};
            checks++;
            if (o_busy !== eb) begin failures++; $display("FAIL indep_busy m=%0d got=%b exp=%b", m, o_busy, eb); end
            checks++;
            if (o_pulse !== ep) begin failures++; $display("FAIL indep_pulse m=%0d got=%b exp=%b", m, o_pulse, ep); end
            checks++;
            if (o_miss !== 4'b0) begin failures++; $display("FAIL indep_miss m=%0d got=%b exp=0000", m, o_miss); end
            if (k == 4) i_trigger = 1'b0;
        end
        exp_cnt = exp_cnt + 8'd1;
        checks++;
        if (o_trig_cnt !== exp_cnt) begin failures++; $display("FAIL indep_cnt got=%0d exp=%0d", o_trig_cnt, exp_cnt); end
        i_en = '0;
    endtask

    task automatic test_retrigger();
        logic [N_CH-1:0] eb, ep, em;
        int m;
        i_en = 4'b0010;
        set_ch(1, 20, 5);
        idle(2);
        i_trigger = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            step();
            m  = k - 3;
            eb = {2'b00, ((m >= 1 && m <= 25) || (m >= 27 && m <= 34)), 1'b0};
            ep = {2'b00, ((m >= 21 && m <= 25) || (m >= 30 && m <= 34)), 1'b0};
            em = {2'b00, (m == 11), 1'b0};
            checks++;
            if (o_busy !== eb) begin failures++; $display("FAIL retrig_busy m=%0d got=%b exp=%b", m, o_busy, eb); end
            checks++;
            if (o_pulse !== ep) begin failures++; $display("FAIL retrig_pulse m=%0d got=%b exp=%b", m, o_pulse, ep); end
            checks++;
            if (o_miss !== em) begin failures++; $display("FAIL retrig_miss m=%0d got=%b exp=%b", m, o_miss, em); end
            if (k == 4)  i_trigger = 1'b0;
            if (k == 8)  set_ch(1, 3, 5);
            if (k == 10) i_trigger = 1'b1;
            if (k == 14) i_trigger = 1'b0;
            if (k == 26) i_trigger = 1'b1;
            if (k == 30) i_trigger = 1'b0;
        end
        exp_cnt = exp_cnt + 8'd3;
        checks++;
        if (o_trig_cnt !== exp_cnt) begin failures++; $display("FAIL retrig_cnt got=%0d exp=%0d", o_trig_cnt, exp_cnt); end
        i_en = '0;
    endtask

    task automatic test_abort();
        logic [N_CH-1:0] eb, ep;
        int m;
        i_en = 4'b0100;
        set_ch(2, 4, 10);
        idle(2);
        i_trigger = 1'b1;
        for (int k = 1; k <= 18; k++) begin
            step();
            m  = k - 3;
            eb = {1'b0, (m >= 1 && m <= 7), 2'b00};
            ep = {1'b0, (m >= 5 && m <= 7), 2'b00};
            checks++;
            if (o_busy !== eb) begin failures++; $display("FAIL abort_busy m=%0d got=%b exp=%b", m, o_busy, eb); end
            checks++;
            if (o_pulse !== ep) begin failures++; $display("FAIL abort_pulse m=%0d got=%b exp=%b", m, o_pulse, ep); end
            if (k == 4)  i_trigger = 1'b0;
            if (k == 10) i_en = 4'b0000;
        end
        i_en = 4'b0100;
        idle(2);
        i_trigger = 1'b1;
        for (int k = 1; k <= 18; k++) begin
            step();
            m  = k - 3;
            eb = {1'b0, (m >= 1 && m <= 5), 2'b00};
            ep = {1'b0, (m == 5), 2'b00};
            checks++;
            if (o_busy !== eb) begin failures++; $display("FAIL abortevt_busy m=%0d got=%b exp=%b", m, o_busy, eb); end
            checks++;
            if (o_pulse !== ep) begin failures++; $display("FAIL abortevt_pulse m=%0d got=%b exp=%b", m, o_pulse, ep); end
            checks++;
            if (o_miss !== 4'b0) begin failures++; $display("FAIL abortevt_miss m=%0d got=%b exp=0000", m, o_miss); end
            if (k == 4) i_trigger = 1'b0;
            if (k == 5) i_trigger = 1'b1;
            if (k == 8) i_en = 4'b0000;
            if (k == 9) i_trigger = 1'b0;
        end
        exp_cnt = exp_cnt + 8'd3;
        checks++;
        if (o_trig_cnt !== exp_cnt) begin failures++; $display("FAIL abort_cnt got=%0d exp=%0d", o_trig_cnt, exp_cnt); end
    endtask

    task automatic test_async_reset();
        i_en = 4'b0001;
        set_ch(0, 2, 20);
        idle(2);
        i_trigger = 1'b1;
        for (int k = 1; k <= 13; k++) begin
            step();
            if (k == 4) i_trigger = 1'b0;
        end
        checks++;
        if (o_pulse !== 4'b0001) begin failures++; $display("FAIL areset_pre_pulse got=%b exp=0001", o_pulse); end
        #2;
        i_rst_n = 1'b0;
        #1;
        checks++;
        if (o_pulse !== 4'b0) begin failures++; $display("FAIL areset_pulse got=%b exp=0000", o_pulse); end
        checks++;
        if (o_busy !== 4'b0) begin failures++; $display("FAIL areset_busy got=%b exp=0000", o_busy); end
        checks++;
        if (o_trig_cnt !== 8'd0) begin failures++; $display("FAIL areset_cnt got=%0d exp=0", o_trig_cnt); end
        idle(2);
        i_en = '0;
        i_rst_n = 1'b1;
        idle(3);
        exp_cnt = '0;
        checks++;
        if (o_busy !== 4'b0) begin failures++; $display("FAIL areset_after_busy got=%b exp=0000", o_busy); end
    endtask

    task automatic test_wrap_long();
        i_en = '0;
        i_trigger = 1'b1;
        idle(100);
        i_trigger = 1'b0;
        idle(5);
        exp_cnt = exp_cnt + 8'd1;
        checks++;
        if (o_trig_cnt !== exp_cnt) begin failures++; $display("FAIL long_trig_cnt got=%0d exp=%0d", o_trig_cnt, exp_cnt); end
        while (exp_cnt != 8'd255) begin
            i_trigger = 1'b1;
            idle(3);
            i_trigger = 1'b0;
            idle(3);
            exp_cnt = exp_cnt + 8'd1;
        end
        idle(4);
        checks++;
        if (o_trig_cnt !== 8'd255) begin failures++; $display("FAIL wrap_pre got=%0d exp=255", o_trig_cnt); end
        i_trigger = 1'b1;
        idle(3);
        i_trigger = 1'b0;
        idle(5);
        checks++;
        if (o_trig_cnt !== 8'd0) begin failures++; $display("FAIL wrap_zero got=%0d exp=0", o_trig_cnt); end
    endtask

    initial begin
        i_rst_n   = 1'b0;
        i_trigger = 1'b0;
        i_en      = '0;
        i_delay   = '0;
        i_width   = '0;
        exp_cnt   = '0;
        test_reset();
        test_basic();
        test_independent();
        test_retrigger();
        test_abort();
        test_async_reset();
        test_wrap_long();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
